// File: rtl/route_cntrl.sv
// Route command controller: queues destination station IDs and retires them as stations are read.
// Optional piezo obstruction alarm is built only when PIEZO_EN is defined.
module route_cntrl #(
   parameter int ID_W     = 6,
   parameter int DEPTH    = 4,
   parameter int BUZZ_DIV = 12500
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ID_W+1:0]          cmd,
   input  logic                     cmd_rdy,
   output logic                     clr_cmd_rdy,
   input  logic [ID_W+1:0]          ID,
   input  logic                     ID_vld,
   output logic                     clr_ID_vld,
   input  logic                     OK2Move,
   output logic                     in_transit,
   output logic                     go,
   output logic                     buzz,
   output logic                     buzz_n,
   output logic [$clog2(DEPTH):0]   q_cnt,
   output logic                     q_full,
   output logic                     arrived,
   output logic                     cmd_err
);

   localparam int PW = $clog2(DEPTH);

   localparam logic [1:0] OP_STOP   = 2'b00;
   localparam logic [1:0] OP_GO     = 2'b01;
   localparam logic [1:0] OP_APPEND = 2'b10;

   typedef enum logic {IDLE, TRANSIT} state_t;

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("route_cntrl: DEPTH must be a power of two >= 2");
      end
      if (BUZZ_DIV < 2 || (BUZZ_DIV % 2) != 0) begin : g_bad_div
         $error("route_cntrl: BUZZ_DIV must be even and >= 2");
      end
   endgenerate

   state_t            r_state, w_nstate;
   logic [ID_W-1:0]   r_q [DEPTH];
   logic [PW-1:0]     r_rd, r_wr;
   logic [PW:0]       r_qcnt;
   logic              r_clr_cmd, r_clr_id, r_err, r_arr;

   logic              w_cmd_take, w_id_take, w_id_match, w_full;
   logic              w_flush, w_push, w_pop, w_err, w_arr;
   logic [ID_W-1:0]   w_head;

   // A request is taken only while its clear is low; commands win ties and the ID waits.
   assign w_cmd_take = cmd_rdy & ~r_clr_cmd;
   assign w_id_take  = ID_vld & ~r_clr_id & ~w_cmd_take;
   assign w_head     = r_q[r_rd];
   assign w_full     = (r_qcnt == (PW+1)'(DEPTH));
   // Upper ID bits are don't-care; folded in as a zero term so they count as consumed.
   assign w_id_match = (ID[ID_W-1:0] == w_head) | (1'b0 & ^ID[ID_W+1:ID_W]);

   always_comb begin
      w_nstate = r_state;
      w_flush  = 1'b0;
      w_push   = 1'b0;
      w_pop    = 1'b0;
      w_err    = 1'b0;
      w_arr    = 1'b0;
      if (w_cmd_take) begin
         case (cmd[ID_W+1:ID_W])
            OP_STOP: begin
               w_flush  = 1'b1;
               w_nstate = IDLE;
            end
            OP_GO: begin
               w_flush  = 1'b1;
               w_push   = 1'b1;
               w_nstate = TRANSIT;
            end
            OP_APPEND: begin
               if (w_full) begin
                  w_err = 1'b1;
               end else begin
                  w_push   = 1'b1;
                  w_nstate = TRANSIT;
               end
            end
            default: w_err = 1'b1;
         endcase
      end else if (w_id_take && r_state == TRANSIT && r_qcnt != '0 && w_id_match) begin
         w_pop = 1'b1;
         if (r_qcnt == (PW+1)'(1)) begin
            w_nstate = IDLE;
            w_arr    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_clr_cmd <= 1'b0;
         r_clr_id  <= 1'b0;
         r_err     <= 1'b0;
         r_arr     <= 1'b0;
      end else begin
         r_state   <= w_nstate;
         r_clr_cmd <= w_cmd_take;
         r_clr_id  <= w_id_take;
         r_err     <= w_err;
         r_arr     <= w_arr;
      end
   end

   // Flush and push can coincide (GO): the new entry lands in slot 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd   <= '0;
         r_wr   <= '0;
         r_qcnt <= '0;
         for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      end else if (w_flush) begin
         r_rd <= '0;
         if (w_push) begin
            r_q[0] <= cmd[ID_W-1:0];
            r_wr   <= PW'(1);
            r_qcnt <= (PW+1)'(1);
         end else begin
            r_wr   <= '0;
            r_qcnt <= '0;
         end
      end else if (w_push) begin
         r_q[r_wr] <= cmd[ID_W-1:0];
         r_wr      <= r_wr + 1'b1;
         r_qcnt    <= r_qcnt + 1'b1;
      end else if (w_pop) begin
         r_rd   <= r_rd + 1'b1;
         r_qcnt <= r_qcnt - 1'b1;
      end
   end

   assign clr_cmd_rdy = r_clr_cmd;
   assign clr_ID_vld  = r_clr_id;
   assign cmd_err     = r_err;
   assign arrived     = r_arr;
   assign in_transit  = (r_state == TRANSIT);
   assign go          = in_transit & OK2Move;
   assign q_cnt       = r_qcnt;
   assign q_full      = w_full;

`ifdef PIEZO_EN
   localparam int CW   = (BUZZ_DIV > 2) ? $clog2(BUZZ_DIV) : 1;
   localparam int HALF = BUZZ_DIV / 2;

   logic          w_alarm;
   logic [CW-1:0] r_bcnt;
   logic          r_buzz, r_buzz_n;

   assign w_alarm = in_transit & ~OK2Move;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcnt   <= '0;
         r_buzz   <= 1'b0;
         r_buzz_n <= 1'b0;
      end else if (w_alarm) begin
         r_bcnt   <= (r_bcnt == CW'(BUZZ_DIV - 1)) ? '0 : r_bcnt + 1'b1;
         r_buzz   <= (r_bcnt >= CW'(HALF));
         r_buzz_n <= (r_bcnt <  CW'(HALF));
      end else begin
         r_bcnt   <= '0;
         r_buzz   <= 1'b0;
         r_buzz_n <= 1'b0;
      end
   end

   assign buzz   = r_buzz;
   assign buzz_n = r_buzz_n;
`else
   assign buzz   = 1'b0;
   assign buzz_n = 1'b0;
`endif

endmodule

// File: tb/tb_route_cntrl.sv
// Bench for route_cntrl: directed vector table, randomized run against a queue model, corner sequences.
module tb_route_cntrl;
   localparam int ID_W = 6, DEPTH = 4, BUZZ_DIV = 8;

   logic clk = 0, rst_n = 0;
   logic [ID_W+1:0] cmd = '0, ID = '0;
   logic cmd_rdy = 0, ID_vld = 0, OK2Move = 1;
   logic clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n, q_full, arrived, cmd_err;
   logic [$clog2(DEPTH):0] q_cnt;

   route_cntrl #(.ID_W(ID_W), .DEPTH(DEPTH), .BUZZ_DIV(BUZZ_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
      .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld), .OK2Move(OK2Move),
      .in_transit(in_transit), .go(go), .buzz(buzz), .buzz_n(buzz_n),
      .q_cnt(q_cnt), .q_full(q_full), .arrived(arrived), .cmd_err(cmd_err));

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // One request on one channel, held until its clear, with cycle-exact checks.
   task automatic apply(input bit is_id, input logic [1:0] op, input logic [7:0] val,
                        input bit e_err, input bit e_arr, input bit e_tr, input int e_cnt);
      if (is_id) begin ID = val; ID_vld = 1; end
      else begin cmd = {op, val[ID_W-1:0]}; cmd_rdy = 1; end
      @(posedge clk); #1;
      chk(is_id ? "clr_ID_vld" : "clr_cmd_rdy", is_id ? clr_ID_vld : clr_cmd_rdy, 1);
      chk("other_clr", is_id ? clr_cmd_rdy : clr_ID_vld, 0);
      chk("cmd_err", cmd_err, e_err);
      chk("arrived", arrived, e_arr);
      chk("in_transit", in_transit, e_tr);
      chk("q_cnt", q_cnt, e_cnt);
      chk("q_full", q_full, e_cnt == DEPTH);
      chk("go", go, e_tr & OK2Move);
      cmd_rdy = 0; ID_vld = 0;
      @(posedge clk); #1;
      chk("clr_drop", clr_cmd_rdy | clr_ID_vld, 0);
      chk("pulse_drop", cmd_err | arrived, 0);
   endtask

   typedef struct {
      bit is_id; logic [1:0] op; logic [7:0] val;
      bit e_err; bit e_arr; bit e_tr; int e_cnt;
   } vec_t;
   vec_t vt[$];

   int mq[$];
   bit mtr;

   initial begin
      // GO, then arrival
      vt.push_back('{0, 2'd1, 8'h05, 0, 0, 1, 1});
      vt.push_back('{1, 2'd0, 8'h05, 0, 1, 0, 0});
      // fill, overflow, retire with a mismatch in the middle
      vt.push_back('{0, 2'd1, 8'h01, 0, 0, 1, 1});
      vt.push_back('{0, 2'd2, 8'h02, 0, 0, 1, 2});
      vt.push_back('{0, 2'd2, 8'h03, 0, 0, 1, 3});
      vt.push_back('{0, 2'd2, 8'h04, 0, 0, 1, 4});
      vt.push_back('{0, 2'd2, 8'h07, 1, 0, 1, 4});
      vt.push_back('{1, 2'd0, 8'h01, 0, 0, 1, 3});
      vt.push_back('{1, 2'd0, 8'h09, 0, 0, 1, 3});
      vt.push_back('{1, 2'd0, 8'h02, 0, 0, 1, 2});
      vt.push_back('{1, 2'd0, 8'h03, 0, 0, 1, 1});
      vt.push_back('{1, 2'd0, 8'h04, 0, 1, 0, 0});
      // ID in IDLE, reserved opcode, APPEND from IDLE
      vt.push_back('{1, 2'd0, 8'h04, 0, 0, 0, 0});
      vt.push_back('{0, 2'd3, 8'h00, 1, 0, 0, 0});
      vt.push_back('{0, 2'd2, 8'h11, 0, 0, 1, 1});
      // pointer wrap: 3 queued, pop 2, append 3, retire in order
      vt.push_back('{0, 2'd1, 8'h01, 0, 0, 1, 1});
      vt.push_back('{0, 2'd2, 8'h02, 0, 0, 1, 2});
      vt.push_back('{0, 2'd2, 8'h03, 0, 0, 1, 3});
      vt.push_back('{1, 2'd0, 8'h01, 0, 0, 1, 2});
      vt.push_back('{1, 2'd0, 8'h02, 0, 0, 1, 1});
      vt.push_back('{0, 2'd2, 8'h04, 0, 0, 1, 2});
      vt.push_back('{0, 2'd2, 8'h05, 0, 0, 1, 3});
      vt.push_back('{0, 2'd2, 8'h06, 0, 0, 1, 4});
      vt.push_back('{1, 2'd0, 8'h04, 0, 0, 1, 4});
      vt.push_back('{1, 2'd0, 8'h03, 0, 0, 1, 3});
      vt.push_back('{1, 2'd0, 8'h04, 0, 0, 1, 2});
      vt.push_back('{1, 2'd0, 8'h05, 0, 0, 1, 1});
      vt.push_back('{1, 2'd0, 8'h06, 0, 1, 0, 0});
      // upper ID bits ignored; STOP from TRANSIT
      vt.push_back('{0, 2'd1, 8'h0A, 0, 0, 1, 1});
      vt.push_back('{1, 2'd0, 8'hCA, 0, 1, 0, 0});
      vt.push_back('{0, 2'd1, 8'h02, 0, 0, 1, 1});
      vt.push_back('{0, 2'd2, 8'h03, 0, 0, 1, 2});
      vt.push_back('{0, 2'd0, 8'h00, 0, 0, 0, 0});

      // reset state
      #12;
      chk("rst_outs", {clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n, q_full, arrived, cmd_err}, 0);
      chk("rst_q_cnt", q_cnt, 0);
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;

      foreach (vt[i])
         apply(vt[i].is_id, vt[i].op, vt[i].val, vt[i].e_err, vt[i].e_arr, vt[i].e_tr, vt[i].e_cnt);

      // STOP and matching ID together: STOP wins, ID cleared afterwards with no arrival
      apply(0, 2'd1, 8'h05, 0, 0, 1, 1);
      cmd = {2'b00, 6'h00}; cmd_rdy = 1; ID = 8'h05; ID_vld = 1;
      @(posedge clk); #1;
      chk("tie_clr_cmd", clr_cmd_rdy, 1);
      chk("tie_clr_id", clr_ID_vld, 0);
      chk("tie_transit", in_transit, 0);
      chk("tie_q_cnt", q_cnt, 0);
      cmd_rdy = 0;
      @(posedge clk); #1;
      chk("tie_id_clr", clr_ID_vld, 1);
      chk("tie_no_arrive", arrived, 0);
      ID_vld = 0;
      @(posedge clk); #1;
      chk("tie_id_drop", clr_ID_vld, 0);

      // asynchronous reset mid-route
      apply(0, 2'd1, 8'h03, 0, 0, 1, 1);
      apply(0, 2'd2, 8'h04, 0, 0, 1, 2);
      #2 rst_n = 0;
      #1;
      chk("arst_transit", in_transit, 0);
      chk("arst_q_cnt", q_cnt, 0);
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;
      chk("arst_after", {in_transit, go, arrived, cmd_err}, 0);

      // randomized run against queue model
      mq.delete(); mtr = 0;
      for (int i = 0; i < 400; i++) begin
         bit e_err, e_arr;
         logic [1:0] op;
         logic [7:0] v;
         bit is_id;
         e_err = 0; e_arr = 0;
         OK2Move = ($urandom_range(0, 3) != 0);
         is_id = $urandom_range(0, 1);
         if (!is_id) begin
            int r;
            r = $urandom_range(0, 9);
            op = (r == 0) ? 2'd0 : (r <= 2) ? 2'd1 : (r <= 8) ? 2'd2 : 2'd3;
            v = 8'($urandom_range(0, 7));
            case (op)
               2'd0: begin mq.delete(); mtr = 0; end
               2'd1: begin mq.delete(); mq.push_back(int'(v)); mtr = 1; end
               2'd2: if (mq.size() < DEPTH) begin mq.push_back(int'(v)); mtr = 1; end
                     else e_err = 1;
               default: e_err = 1;
            endcase
         end else begin
            op = 2'd0;
            if (mq.size() > 0 && $urandom_range(0, 2) != 0)
               v = 8'(mq[0] + 64 * $urandom_range(0, 3));
            else
               v = 8'($urandom_range(0, 255));
            if (mtr && mq.size() > 0 && int'(v % 64) == mq[0]) begin
               void'(mq.pop_front());
               if (mq.size() == 0) begin mtr = 0; e_arr = 1; end
            end
         end
         apply(is_id, op, v, e_err, e_arr, mtr, mq.size());
      end

      // piezo alarm
      OK2Move = 1;
      apply(0, 2'd1, 8'h01, 0, 0, 1, 1);
      OK2Move = 0;
      #1 chk("go_blocked", go, 0);
      begin
         int last_t, toggles;
         logic prev;
         last_t = -1; toggles = 0; prev = buzz;
         for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
`ifdef PIEZO_EN
            chk("buzz_n_compl", buzz_n, !buzz);
            if (buzz != prev) begin
               if (last_t >= 0) chk("buzz_half_period", k - last_t, BUZZ_DIV / 2);
               last_t = k; toggles++;
            end
            prev = buzz;
`else
            chk("buzz_off", {buzz, buzz_n}, 0);
`endif
         end
`ifdef PIEZO_EN
         chk("buzz_toggles", toggles >= 4, 1);
`endif
      end
      OK2Move = 1;
      #1 chk("go_resume", go, 1);
      @(posedge clk); @(posedge clk); #1;
      chk("buzz_quiet", {buzz, buzz_n}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish, got 0 expected 1");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/route_cntrl.md
# route_cntrl

Parametrised command controller for the line-following vehicle. It sits between the UART command receiver and the drive logic, and queues up to DEPTH destination station IDs. It asserts in_transit while a route is pending and retires each destination as its station ID is read. It also drives go to the motor logic and an optional piezo obstruction alarm.

## Interface
Parameters:
- ID_W, 6: station ID width. cmd and ID are ID_W+2 bits.
- DEPTH, 4: route queue depth. Power of two, ≥2.
- BUZZ_DIV, 12500: piezo period in clocks. Even.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- cmd  in  ID_W+2  command; [ID_W+1:ID_W] opcode, [ID_W-1:0] destination.
- cmd_rdy  in  1  cmd valid; held by source until clr_cmd_rdy.
- clr_cmd_rdy  out  1  registered one-cycle pulse; command consumed.
- ID  in  ID_W+2  station ID from barcode reader; only [ID_W-1:0] compared.
- ID_vld  in  1  ID valid; held until clr_ID_vld.
- clr_ID_vld  out  1  registered one-cycle pulse; ID consumed.
- OK2Move  in  1  no obstacle.
- in_transit  out  1  registered; high in TRANSIT.
- go  out  1  in_transit & OK2Move (combinational).
- buzz, buzz_n  out  1  differential piezo drive.
- q_cnt  out  $clog2(DEPTH)+1  entries queued.
- q_full  out  1  q_cnt == DEPTH.
- arrived  out  1  registered one-cycle pulse; final destination reached.
- cmd_err  out  1  registered one-cycle pulse; command rejected.

## Operation
- Opcodes: 00 STOP, 01 GO, 10 APPEND, 11 reserved.
- States: IDLE, TRANSIT. Reset → IDLE with queue empty.
- A request is sampled only when its clear pulse is low in the same cycle. This prevents double consumption.
- Every sampled command produces clr_cmd_rdy the next cycle. Every sampled ID produces clr_ID_vld the next cycle.
- GO, any state: flush queue, enqueue dest (q_cnt=1), → TRANSIT.
- APPEND, not full: enqueue at tail, → TRANSIT if in IDLE.
- APPEND, full: queue unchanged, cmd_err pulse.
- STOP: flush queue, → IDLE.
- Reserved opcode: cmd_err pulse, no other effect.
- ID_vld in TRANSIT, ID[ID_W-1:0] == head: pop head. If q_cnt becomes 0, → IDLE and pulse arrived.
- ID_vld in TRANSIT, mismatch: clear only.
- ID_vld in IDLE: clear only.
- cmd_rdy and ID_vld sampled in the same cycle: the command is processed and the ID is left pending. The ID is evaluated on the following eligible cycle against the updated queue.
- Queue: circular buffer with rd/wr pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. A flush zeroes both pointers and q_cnt.
- Piezo (PIEZO_EN only): alarm = in_transit & ~OK2Move.
  - While alarm is high, a counter runs 0..BUZZ_DIV-1 and wraps. buzz = (cnt ≥ BUZZ_DIV/2), registered. buzz_n = ~buzz.
  - While alarm is low, the counter is held at 0 and buzz = buzz_n = 0.

## Timing
- All outputs are 0 in reset, including buzz_n. q_cnt = 0.
- Command latency: sampled at edge N. State, queue, clr_cmd_rdy and cmd_err update at edge N+1.
- ID latency: same as command latency. in_transit, arrived and clr_ID_vld update together.
- go follows OK2Move combinationally within the cycle.
- Minimum request spacing is 2 cycles per channel, because the clear is high for one cycle.
- Reset mid-route flushes the queue immediately. Outputs are forced low asynchronously.

## Configuration
- PIEZO_EN defined: piezo divider and counter are built as described.
- PIEZO_EN undefined: no counter logic; buzz = buzz_n = 0 constantly. All other behaviour is identical.

## Test plan
- ID_W=6, DEPTH=4. Send GO dest 0x05 → clr_cmd_rdy pulses 1 cycle later, in_transit=1, q_cnt=1. Send ID 0x05 → clr_ID_vld pulse, in_transit=0, arrived pulse.
- Send GO 0x01, then APPEND 0x02, 0x03, 0x04 → q_full=1. A fifth APPEND 0x07 → cmd_err pulse, q_cnt stays 4.
- Send IDs 0x01, 0x09, 0x02, 0x03, 0x04 → 0x09 is cleared with no pop. arrived pulses only after 0x04; q_cnt steps 4→3→3→2→1→0.
- Wrap-around check: with 3 entries queued, pop 2 and append 3 → pointers wrap. IDs are retired in append order.
- Assert cmd_rdy (STOP) and ID_vld (matching head) in the same cycle → STOP wins, queue flushed, IDLE. The ID is then cleared without arrived.
- In TRANSIT with OK2Move=0 and BUZZ_DIV=8 → buzz toggles every 4 cycles and buzz_n is its complement, go=0. With OK2Move=1 → both piezo outputs go low and go=1. With PIEZO_EN undefined → both piezo outputs stay low.
